// File: rtl/pc_sequencer.sv
// Fetch-control FSM for the program-counter register: decodes step/jump/call/return
// and stall commands into PC enable/hold/load/step controls and owns the return-address stack.
module pc_sequencer #(
  parameter int unsigned PC_W        = 8,
  parameter int unsigned STEP_W      = 3,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         halt,
  input  logic                         stall,
  input  logic [STEP_W-1:0]            instr_len,
  input  logic                         jmp,
  input  logic                         call,
  input  logic                         ret,
  input  logic [PC_W-1:0]              target,
  input  logic [PC_W-1:0]              pc_in,
  output logic                         pc_enable,
  output logic                         pc_hold,
  output logic                         pc_load,
  output logic [PC_W-1:0]              pc_load_value,
  output logic [STEP_W-1:0]            pc_step,
  output logic                         fetch_valid,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         fault
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_BUBBLE,
    S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              fault_q, fault_d;
  logic [PC_W-1:0]   stack_q [STACK_DEPTH];

  logic              push_en;
  logic [PC_W-1:0]   ret_addr;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              stack_empty;
  logic              stack_full;

  logic              en_c, hold_c, load_c, fv_c;
  logic [PC_W-1:0]   lv_c;
  logic [STEP_W-1:0] step_c;

  assign ret_addr    = pc_in + PC_W'(instr_len);
  assign top_idx     = IDX_W'(sp_q - 1'b1);
  assign wr_idx      = sp_q[IDX_W-1:0];
  assign stack_empty = (sp_q == '0);
  assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    fault_d = fault_q;
    push_en = 1'b0;
    en_c    = 1'b0;
    hold_c  = 1'b0;
    load_c  = 1'b0;
    lv_c    = '0;
    step_c  = '0;
    fv_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        fv_c = 1'b1;
        if (halt) begin
          state_d = S_IDLE;
        end else if (stall) begin
          en_c   = 1'b1;
          hold_c = 1'b1;
          fv_c   = 1'b0;
        end else if (ret) begin
          if (stack_empty) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            en_c    = 1'b1;
            load_c  = 1'b1;
            lv_c    = stack_q[top_idx];
            sp_d    = sp_q - 1'b1;
            state_d = S_BUBBLE;
          end
        end else if (call) begin
          if (stack_full) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            push_en = 1'b1;
            en_c    = 1'b1;
            load_c  = 1'b1;
            lv_c    = target;
            sp_d    = sp_q + 1'b1;
            state_d = S_BUBBLE;
          end
        end else if (jmp) begin
          en_c    = 1'b1;
          load_c  = 1'b1;
          lv_c    = target;
          state_d = S_BUBBLE;
        end else begin
          en_c   = 1'b1;
          step_c = instr_len;
        end
      end
      S_BUBBLE: begin
        en_c    = 1'b1;
        hold_c  = 1'b1;
        state_d = halt ? S_IDLE : S_RUN;
      end
      S_FAULT: begin
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Gate with reset_n so nothing reaches the PC register while reset is held.
  assign pc_enable     = en_c & reset_n;
  assign pc_hold       = hold_c & reset_n;
  assign pc_load       = load_c & reset_n;
  assign pc_load_value = reset_n ? lv_c : '0;
  assign pc_step       = reset_n ? step_c : '0;
  assign fetch_valid   = fv_c & reset_n;
  assign sp            = sp_q;
  assign fault         = fault_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      fault_q <= 1'b0;
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
      if (push_en) stack_q[wr_idx] <= ret_addr;
    end
  end

endmodule
